// File: rtl/io_sync_gen.sv
// Purpose: 1 MHz / 1 kHz sync strobe generator with 32-bit uptime counter and an IO register window.
// Latency: strobes are registered and rise one enabled edge after the internal hit; IO reads are combinational.
// Backpressure: none; AClkHEn=0 freezes every register, including a strobe that is currently high.
//
// Ports:
//   AClkH, AResetHN, AClkHEn      clock, async active-low reset, clock enable
//   AIoAddr/AIoMosi/AIoMiso      IO address, write data, read data (LSB-aligned, 0 when not addressed)
//   AIoWrSize/AIoRdSize          one-hot access size per direction: 0001 byte, 0010 word, 0100 dword
//   AIoAddrAck/AIoAddrErr        window hit / hit with an illegal offset, size or direction
//   ASync1M/ASync1K              one-cycle strobes
//   ATest                        {AClkH, En1M, En1K, BPreHit, BKHit, ASync1M, ASync1K, FUptime[0]}
//
// Register window (offset from CAddrBase):
//   +0 word R/W  IowDiv     prescaler divider; a write also restarts the phase
//   +2 byte W    IobCtrl    bit7 Restart, bit1 En1K, bit0 En1M; read returns {6'h0, En1K, En1M}
//   +3 dword R   IodUptime  32-bit count of 1 kHz strobes
//   +3 byte W    IobUpClr   bit0 clears the uptime counter
module io_sync_gen #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter logic [15:0] CDivRst   = 16'd47
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [63:0] AIoMosi,
  output logic [63:0] AIoMiso,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  output logic        ASync1M,
  output logic        ASync1K,
  output logic [7:0]  ATest
);

  localparam logic [3:0] LSzByte  = 4'b0001;
  localparam logic [3:0] LSzWord  = 4'b0010;
  localparam logic [3:0] LSzDword = 4'b0100;

  logic [15:0] r_div;
  logic        r_en1m;
  logic        r_en1k;
  logic [15:0] r_pre;
  logic [9:0]  r_k;
  logic [31:0] r_uptime;
  logic        r_sync1m;
  logic        r_sync1k;

  logic [15:0] w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_hit;
  logic        w_acc_ok;
  logic        w_wr_div;
  logic        w_rd_div;
  logic        w_wr_ctrl;
  logic        w_rd_ctrl;
  logic        w_rd_up;
  logic        w_wr_clr;
  logic        w_legal;
  logic        w_restart;
  logic        w_pre_hit;
  logic        w_k_hit;
  logic        w_up_inc;
  logic        w_up_clr;
  logic        w_unused;

  // ---------------------------------------------------------------------------
  // IO decode: a 4-byte window; exactly one direction per access is legal.
  // ---------------------------------------------------------------------------
  assign w_off      = AIoAddr - CAddrBase;
  assign w_wr       = |AIoWrSize;
  assign w_rd       = |AIoRdSize;
  assign w_hit      = (w_off < 16'd4) & (w_wr | w_rd);
  assign w_acc_ok   = w_hit & (w_wr ^ w_rd);

  assign w_wr_div   = w_acc_ok & w_wr & (w_off[1:0] == 2'd0) & (AIoWrSize == LSzWord);
  assign w_rd_div   = w_acc_ok & w_rd & (w_off[1:0] == 2'd0) & (AIoRdSize == LSzWord);
  assign w_wr_ctrl  = w_acc_ok & w_wr & (w_off[1:0] == 2'd2) & (AIoWrSize == LSzByte);
  assign w_rd_ctrl  = w_acc_ok & w_rd & (w_off[1:0] == 2'd2) & (AIoRdSize == LSzByte);
  assign w_rd_up    = w_acc_ok & w_rd & (w_off[1:0] == 2'd3) & (AIoRdSize == LSzDword);
  assign w_wr_clr   = w_acc_ok & w_wr & (w_off[1:0] == 2'd3) & (AIoWrSize == LSzByte);
  assign w_legal    = w_wr_div | w_rd_div | w_wr_ctrl | w_rd_ctrl | w_rd_up | w_wr_clr;

  assign AIoAddrAck = w_hit;
  assign AIoAddrErr = w_hit & ~w_legal;

  // Read data is gated by reset so the bus shows zero while reset is held.
  always_comb begin
    AIoMiso = '0;
    if (AResetHN) begin
      if (w_rd_div)  AIoMiso = {48'h0, r_div};
      if (w_rd_ctrl) AIoMiso = {56'h0, 6'h0, r_en1k, r_en1m};
      if (w_rd_up)   AIoMiso = {32'h0, r_uptime};
    end
  end

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  // A divider write or a Restart write realigns the phase and kills any hit
  // that would otherwise land on the same edge.
  assign w_restart = w_wr_div | (w_wr_ctrl & AIoMosi[7]);
  assign w_pre_hit = r_en1m & (r_pre == r_div) & ~w_restart;
  assign w_k_hit   = w_pre_hit & (r_k == 10'd999);
  assign w_up_inc  = w_k_hit & r_en1k;
  assign w_up_clr  = w_wr_clr & AIoMosi[0];

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_div    <= CDivRst;
      r_en1m   <= 1'b1;
      r_en1k   <= 1'b1;
      r_pre    <= '0;
      r_k      <= '0;
      r_uptime <= '0;
      r_sync1m <= 1'b0;
      r_sync1k <= 1'b0;
    end else if (AClkHEn) begin
      if (w_wr_div) r_div <= AIoMosi[15:0];
      if (w_wr_ctrl) begin
        r_en1m <= AIoMosi[0];
        r_en1k <= AIoMosi[1];
      end

      if (w_restart || !r_en1m || (r_pre == r_div)) r_pre <= '0;
      else                                          r_pre <= r_pre + 16'd1;

      // Kilo counter only advances on prescaler hits and stays parked at 0
      // while the 1 MHz timebase is disabled.
      if (w_restart || !r_en1m) r_k <= '0;
      else if (w_pre_hit)       r_k <= w_k_hit ? 10'd0 : r_k + 10'd1;

      r_sync1m <= w_pre_hit;
      r_sync1k <= w_up_inc;

      // Clear wins over a coincident increment.
      if (w_up_clr)      r_uptime <= '0;
      else if (w_up_inc) r_uptime <= r_uptime + 32'd1;
    end
  end

  assign ASync1M  = r_sync1m;
  assign ASync1K  = r_sync1k;
  assign ATest    = {AClkH, r_en1m, r_en1k, w_pre_hit, w_k_hit, r_sync1m, r_sync1k, r_uptime[0]};

  assign w_unused = ^AIoMosi[63:16];

endmodule

// File: doc/io_sync_gen.md
IO_SYNC_GEN -- requirements
Module: io_sync_gen

Interface
REQ-001 SHALL have parameter CAddrBase, default 16'h0000, the IO base address of the register window.
REQ-002 SHALL have parameter CDivRst, default 16'd47, the reset value of the divider register (1 MHz from 48 MHz AClkH).
REQ-003 SHALL use one clock and an asynchronous, active-low reset (AClkH, AResetHN).
REQ-004 AClkH  in  1  system clock; all state updates on its rising edge.
REQ-005 AResetHN  in  1  asynchronous active-low reset.
REQ-006 AClkHEn  in  1  clock enable; when 0, all registers hold their value.
REQ-007 AIoAddr  in  16  IO address.
REQ-008 AIoMosi  in  64  IO write data, LSB-aligned.
REQ-009 AIoMiso  out  64  IO read data, LSB-aligned, zero when not addressed.
REQ-010 AIoWrSize/AIoRdSize  in  4 each  IO access size and strobe (byte/word/dword).
REQ-011 AIoAddrAck/AIoAddrErr  out  1 each  address hit / hit with illegal size or direction, produced by the standard IO interface decoder.
REQ-012 ASync1M  out  1  registered one-cycle 1 MHz strobe.
REQ-013 ASync1K  out  1  registered one-cycle 1 kHz strobe.
REQ-014 ATest  out  8  {AClkH, En1M, En1K, BPreHit, BKHit, ASync1M, ASync1K, FUptime[0]}.

Function
REQ-015 Register map: IowDiv at +0 (R/W, 16 bit); IobCtrl at +2 (W: bit7 Restart, bit1 En1K, bit0 En1M; R: {6'h0, En1K, En1M}); IodUptime at +3 (R, 32 bit); IobUpClr at +3 (W, bit0 clears uptime). All other offset/size/direction combinations SHALL raise AIoAddrErr and SHALL have no effect.
REQ-016 Prescaler FPre (16 bit): when En1M=1, FPre==FDiv sets BPreHit and loads 0; otherwise increments by 1. Strobe period = FDiv+1 enabled cycles.
REQ-017 ASync1M SHALL equal BPreHit registered, so it goes high one cycle after the hit. FDiv=0 SHALL hold ASync1M high continuously.
REQ-018 Kilo counter FK (10 bit): on every BPreHit, FK==999 sets BKHit and loads 0; otherwise increments. FK SHALL hold while there is no BPreHit.
REQ-019 ASync1K SHALL equal (BKHit & En1K) registered, so it coincides with the ASync1M pulse of the 1000th hit.
REQ-020 Uptime FUptime (32 bit) SHALL increment on every (BKHit & En1K) and wrap from FFFF_FFFF to 0.
REQ-021 En1M=0: FPre and FK held at 0, no strobes. En1K=0: FK still counts, ASync1K stays 0, FUptime holds.
REQ-022 A write to IowDiv, or an IobCtrl write with bit7=1, SHALL load FPre=0 and FK=0 in the same edge and suppress any hit in that cycle (phase restart).
REQ-023 An IobUpClr write with bit0=1 SHALL load FUptime=0, and this takes priority over a simultaneous increment.
REQ-024 Register writes SHALL take effect on the edge of the access. Reads SHALL be combinational from current register values.
REQ-025 With AClkHEn=0, strobes, counters and registers SHALL hold, including a strobe that is currently high.

Reset
REQ-026 Asynchronous assertion of AResetHN=0 SHALL immediately force FDiv=CDivRst, En1M=1, En1K=1, FPre=0, FK=0, FUptime=0, ASync1M=0, ASync1K=0, AIoMiso=0, regardless of AClkHEn or an operation in progress.
REQ-027 After reset release, the first ASync1M SHALL be high in the cycle after the (CDivRst+1)th enabled edge.

Verification
REQ-028 CDivRst=3, AClkHEn=1, no IO -> ASync1M high after edges 4, 8, 12, ...; ASync1K high after edge 4000; IodUptime reads 1 after edge 4000.
REQ-029 Write IowDiv=0 -> ASync1M stays high; ASync1K pulses every 1000 cycles; IowDiv reads 0x0000.
REQ-030 Write IobCtrl=0x01 -> no ASync1K, FUptime frozen, ASync1M unchanged; IobCtrl reads 0x01.
REQ-031 IobUpClr bit0 written in the same cycle as a 1K hit -> IodUptime reads 0.
REQ-032 Toggle AClkHEn low for 5 cycles mid-period (div 3) -> the next ASync1M is delayed by exactly 5 cycles and a strobe that is high stays high for those 5 cycles.
REQ-033 Assert AResetHN at FK=500 mid-period -> outputs are 0 at once; after release, timing restarts per REQ-027; a word write to +2 sets AIoAddrErr=1 and leaves the registers unchanged.
